// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Issue sequencer for a 5-stage in-order pipeline without forwarding. Each
// cycle it decides whether the instruction sitting in ID moves into ID/EX or
// whether a bubble goes into EX instead.
//
// Three things can stop or redirect issue:
//   - a RAW hazard against an older writer still in EX or MEM (and in WB when
//     the register file has no write-before-read bypass),
//   - a multi-cycle ALU op occupying EX,
//   - a taken branch resolved in EX, which flushes IF/ID and squashes ID.
//
// It keeps its own three-slot tag scoreboard (EX/MEM/WB). Each slot holds a
// valid bit, a write-enable bit and a destination register number. The
// scoreboard therefore does not depend on any datapath pipeline registers.
//
// Ports
//   clk_i              rising-edge clock
//   rst_i              synchronous reset, active-high
//   id_valid_i         ID stage holds a real instruction
//   id_rs1_i/id_rs2_i  source register numbers
//   id_use_rs1_i/2_i   instruction reads rs1 / rs2
//   id_rd_i            destination register number
//   id_wr_i            instruction writes rd
//   id_multi_i         instruction is a multi-cycle ALU op
//   ex_branch_taken_i  instruction in EX resolved a taken branch
//   pc_en_o            PC advances or loads
//   ifid_en_o          IF/ID register loads
//   ifid_flush_o       IF/ID register clears to NOP
//   idex_en_o          ID/EX register loads
//   idex_bubble_o      ID/EX loads a NOP instead of the ID contents
//   ctrl_state_o       0 = RUN, 1 = MULTI
//   stall_count_o      saturating count of cycles with pc_en_o = 0
//
// FSM
//   state | meaning
//   RUN   | normal issue; hazard, branch-flush and issue decisions made here
//   MULTI | multi-cycle op held in EX; front end frozen, older ops drain
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 4,
  parameter int MULTI_CYCLES = 4,
  parameter bit WB_BYPASS    = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wr_i,
  input  logic              id_multi_i,
  input  logic              ex_branch_taken_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_en_o,
  output logic              idex_bubble_o,
  output logic              ctrl_state_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_MULTI = 1'b1;

  // The first MULTI cycle is loaded with MULTI_CYCLES-1 and the counter
  // leaves MULTI at 1. The op's issue cycle plus the MULTI cycles therefore
  // give EX occupancy of exactly MULTI_CYCLES.
  localparam int              MC_W     = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;
  localparam logic [MC_W-1:0] MC_INIT  = MC_W'(MULTI_CYCLES - 1);
  localparam bit              MULTI_EN = (MULTI_CYCLES > 1);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [REG_AW-1:0] rd;
  } slot_t;

  logic [0:0]       state_q, state_d;
  logic [MC_W-1:0]  cnt_q, cnt_d;
  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q;

  logic hit_rs1;
  logic hit_rs2;
  logic hazard;

  logic pc_en_c;
  logic ifid_en_c;
  logic ifid_flush_c;
  logic idex_en_c;
  logic idex_bubble_c;

  function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] r);
    return s.vld && s.wr && (s.rd == r);
  endfunction

  // ---------------------------------------------------------------------------
  // RAW hazard detect. Register 0 is hard-wired, so it never hazards.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit_rs1 = (id_rs1_i != '0) &&
              (slot_hit(ex_q, id_rs1_i) || slot_hit(mem_q, id_rs1_i) ||
               (!WB_BYPASS && slot_hit(wb_q, id_rs1_i)));
    hit_rs2 = (id_rs2_i != '0) &&
              (slot_hit(ex_q, id_rs2_i) || slot_hit(mem_q, id_rs2_i) ||
               (!WB_BYPASS && slot_hit(wb_q, id_rs2_i)));
    hazard  = id_valid_i && ((id_use_rs1_i && hit_rs1) || (id_use_rs2_i && hit_rs2));
  end

  // ---------------------------------------------------------------------------
  // Pipeline control and next-state / scoreboard update
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b0;
    idex_bubble_c = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;

    case (state_q)
      ST_RUN: begin
        wb_d  = mem_q;
        mem_d = ex_q;
        if (ex_branch_taken_i && ex_q.vld) begin
          // A taken branch squashes ID regardless of any hazard it may have.
          pc_en_c       = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          ex_d          = '0;
        end else if (hazard) begin
          // Freeze the front end and push a bubble so older writers drain.
          idex_en_c     = 1'b1;
          idex_bubble_c = 1'b1;
          ex_d          = '0;
        end else begin
          pc_en_c   = 1'b1;
          ifid_en_c = 1'b1;
          idex_en_c = 1'b1;
          ex_d.vld  = id_valid_i;
          ex_d.wr   = id_wr_i;
          ex_d.rd   = id_rd_i;
          if (MULTI_EN && id_valid_i && id_multi_i) begin
            state_d = ST_MULTI;
            cnt_d   = MC_INIT;
          end
        end
      end

      ST_MULTI: begin
        // EX keeps the multi op. MEM receives nothing new while WB still
        // retires whatever was ahead of the op.
        mem_d = '0;
        wb_d  = mem_q;
        cnt_d = cnt_q - MC_W'(1);
        if (cnt_q == MC_W'(1)) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      if (!pc_en_c && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. All strobes are held low for the whole time reset is asserted.
  // ---------------------------------------------------------------------------
  assign pc_en_o       = pc_en_c       & ~rst_i;
  assign ifid_en_o     = ifid_en_c     & ~rst_i;
  assign ifid_flush_o  = ifid_flush_c  & ~rst_i;
  assign idex_en_o     = idex_en_c     & ~rst_i;
  assign idex_bubble_o = idex_bubble_c & ~rst_i;
  assign ctrl_state_o  = state_q[0];
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// The stimulus process drives one ID instruction per cycle. For each cycle
// it predicts the control outputs and pushes that prediction into a queue.
// A monitor pops the queue on the falling edge and compares.
//
// The reference model tracks time windows, not pipeline slots:
//   - each issued writer makes its rd hazardous for a range of absolute cycle
//     numbers,
//   - a multi op makes a range of cycles MULTI,
//   - an issued instruction makes EX valid for a range of cycles.
//
// A narrow stall counter is used so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 4;
  localparam int MC     = 4;
  localparam bit WBB    = 1'b1;
  localparam int CW     = 6;
  localparam int SAT    = (1 << CW) - 1;
  localparam int VW     = 6 + CW;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              multi;
  } ins_t;

  typedef struct {
    int rd;
    int lo;
    int hi;
  } win_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2, id_wr, id_multi;
  logic              ex_branch_taken;
  logic              pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, ctrl_state;
  logic [CW-1:0]     stall_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MULTI_CYCLES(MC),
    .WB_BYPASS   (WBB),
    .CNT_W       (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_valid_i       (id_valid),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_use_rs1_i     (id_use_rs1),
    .id_use_rs2_i     (id_use_rs2),
    .id_rd_i          (id_rd),
    .id_wr_i          (id_wr),
    .id_multi_i       (id_multi),
    .ex_branch_taken_i(ex_branch_taken),
    .pc_en_o          (pc_en),
    .ifid_en_o        (ifid_en),
    .ifid_flush_o     (ifid_flush),
    .idex_en_o        (idex_en),
    .idex_bubble_o    (idex_bubble),
    .ctrl_state_o     (ctrl_state),
    .stall_count_o    (stall_count)
  );

  // scoreboard
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            cyc_q[$];
  int            total = 0;
  int            bad   = 0;

  always @(negedge clk) begin
    logic [VW-1:0] e, a;
    string         t;
    int            c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      c = cyc_q.pop_front();
      a = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, ctrl_state, stall_count};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d {pc,ifid,flush,idex,bub,state,stall} got=%b_%0d need=%b_%0d",
                 t, c, a[VW-1 -: 6], a[CW-1:0], e[VW-1 -: 6], e[CW-1:0]);
      end
    end
  end

  // reference model state
  int   cyc        = 0;
  int   multi_last = -1;
  int   ex_first   = -1;
  int   ex_last    = -1;
  int   stall_m    = 0;
  win_t win_q[$];

  function automatic bit hit(input logic [REG_AW-1:0] r, input int c);
    if (r == '0) return 1'b0;
    foreach (win_q[i]) begin
      if (win_q[i].rd == int'(r) && c >= win_q[i].lo && c <= win_q[i].hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  // nxt: 0 = ID holds, 1 = ID consumed, 2 = ID flushed to NOP
  task automatic step(input logic r, input ins_t in, input logic br, input string tag,
                      input bit chk, output int nxt);
    bit   inm, exv, hz;
    logic pc, ife, fl, ide, bub;
    int   c, span;
    win_t w;
    @(posedge clk);
    #1;
    rst             = r;
    id_valid        = in.v;
    id_rs1          = in.rs1;
    id_rs2          = in.rs2;
    id_use_rs1      = in.u1;
    id_use_rs2      = in.u2;
    id_rd           = in.rd;
    id_wr           = in.wr;
    id_multi        = in.multi;
    ex_branch_taken = br;

    c = cyc;
    while (win_q.size() > 0 && win_q[0].hi < c) void'(win_q.pop_front());
    inm = (c <= multi_last);
    exv = (c >= ex_first) && (c <= ex_last);
    hz  = in.v && ((in.u1 && hit(in.rs1, c)) || (in.u2 && hit(in.rs2, c)));
    pc = 0; ife = 0; fl = 0; ide = 0; bub = 0; nxt = 0;

    if (!r && !inm) begin
      if (br && exv) begin
        pc = 1; fl = 1; ide = 1; bub = 1; nxt = 2;
      end else if (hz) begin
        ide = 1; bub = 1;
      end else begin
        pc = 1; ife = 1; ide = 1; nxt = 1;
        if (in.v) begin
          span     = (in.multi && MC > 1) ? MC : 1;
          ex_first = c + 1;
          ex_last  = c + span;
          if (in.multi && MC > 1) multi_last = c + MC - 1;
          if (in.wr) begin
            w.rd = int'(in.rd);
            w.lo = c + 1;
            w.hi = c + span + 1 + (WBB ? 0 : 1);
            win_q.push_back(w);
          end
        end
      end
    end

    if (chk) begin
      exp_q.push_back({pc, ife, fl, ide, bub, inm, CW'(stall_m)});
      tag_q.push_back(tag);
      cyc_q.push_back(c);
    end

    if (r) begin
      multi_last = -1;
      ex_first   = -1;
      ex_last    = -1;
      stall_m    = 0;
      win_q.delete();
    end else if (!pc && stall_m < SAT) begin
      stall_m++;
    end
    cyc++;
  endtask

  function automatic ins_t mk(input logic v, input int rd, input logic wr,
                              input int rs1, input logic u1, input int rs2,
                              input logic u2, input logic m);
    ins_t i;
    i.v = v; i.rd = REG_AW'(rd); i.wr = wr; i.rs1 = REG_AW'(rs1); i.u1 = u1;
    i.rs2 = REG_AW'(rs2); i.u2 = u2; i.multi = m;
    return i;
  endfunction

  // keep presenting one instruction until it issues or is flushed
  task automatic run_ins(input ins_t in, input logic br, input string tag);
    int n;
    int k;
    k = 0;
    step(1'b0, in, br, tag, 1'b1, n);
    while (n == 0 && k < 20) begin
      step(1'b0, in, 1'b0, tag, 1'b1, n);
      k++;
    end
  endtask

  ins_t nop_i;
  ins_t cur;
  int   nx;

  initial begin
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_wr = 0; id_multi = 0; ex_branch_taken = 0;
    nop_i = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // T1: reset for two cycles, then an independent stream
    step(1'b1, nop_i, 1'b0, "reset0", 1'b0, nx);
    step(1'b1, nop_i, 1'b0, "reset1", 1'b1, nx);
    run_ins(mk(1, 1, 1, 5, 1, 6, 1, 0), 1'b0, "t1_indep");
    run_ins(mk(1, 2, 1, 7, 1, 8, 1, 0), 1'b0, "t1_indep");
    run_ins(mk(1, 9, 1, 10, 1, 11, 1, 0), 1'b0, "t1_indep");

    // T2: writer of R3 followed by a reader of R3
    run_ins(mk(1, 3, 1, 4, 1, 5, 1, 0), 1'b0, "t2_add");
    run_ins(mk(1, 6, 1, 3, 1, 4, 1, 0), 1'b0, "t2_sub");
    run_ins(mk(1, 12, 1, 13, 0, 3, 1, 0), 1'b0, "t2_rs2");

    // T3: R0 is never a hazard
    run_ins(mk(1, 0, 1, 1, 0, 1, 0, 0), 1'b0, "t3_wr_r0");
    run_ins(mk(1, 5, 1, 0, 1, 0, 1, 0), 1'b0, "t3_rd_r0");

    // T4: multi-cycle op, then a dependent reader
    step(1'b1, nop_i, 1'b0, "t4_rst", 1'b1, nx);
    run_ins(mk(1, 4, 1, 1, 1, 2, 1, 1), 1'b0, "t4_multi");
    run_ins(mk(1, 7, 1, 1, 1, 2, 1, 0), 1'b0, "t4_after");
    run_ins(mk(1, 8, 1, 4, 1, 0, 0, 0), 1'b0, "t4_dep");

    // T5: taken branch in EX while ID has a RAW hazard
    run_ins(mk(1, 7, 1, 0, 0, 0, 0, 0), 1'b0, "t5_wr");
    run_ins(mk(1, 0, 0, 1, 1, 0, 0, 0), 1'b0, "t5_br");
    run_ins(mk(1, 9, 1, 7, 1, 0, 0, 0), 1'b1, "t5_flush");
    // with EX empty a taken-branch strobe is ignored
    run_ins(nop_i, 1'b0, "t5_nop");
    run_ins(mk(1, 9, 1, 1, 1, 0, 0, 0), 1'b1, "t5_br_noex");

    // T6: reset in the second MULTI cycle
    run_ins(mk(1, 10, 1, 0, 0, 0, 0, 1), 1'b0, "t6_multi");
    step(1'b0, mk(1, 11, 1, 10, 1, 0, 0, 0), 1'b0, "t6_m1", 1'b1, nx);
    step(1'b1, mk(1, 11, 1, 10, 1, 0, 0, 0), 1'b0, "t6_rst", 1'b1, nx);
    run_ins(mk(1, 11, 1, 10, 1, 0, 0, 0), 1'b0, "t6_after");

    // T7: back-to-back multi ops until the stall counter saturates
    for (int i = 0; i < 25; i++) begin
      run_ins(mk(1, 2, 1, 0, 0, 0, 0, 1), 1'b0, "t7_sat");
    end
    run_ins(nop_i, 1'b0, "t7_hold");
    step(1'b1, nop_i, 1'b0, "t7_rst", 1'b1, nx);

    // randomized stream, ID held while the model says the front end is frozen
    cur = nop_i;
    for (int i = 0; i < 800; i++) begin
      logic r, b;
      r = ($urandom_range(99) < 2);
      b = ($urandom_range(99) < 12);
      step(r, cur, b, "rand", 1'b1, nx);
      if (nx == 1) begin
        cur = mk($urandom_range(9) != 0, $urandom_range(7), $urandom_range(3) != 0,
                 $urandom_range(7), $urandom_range(1), $urandom_range(7),
                 $urandom_range(1), $urandom_range(9) == 0);
      end else if (nx == 2) begin
        cur = nop_i;
      end
    end

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
